// File: rtl/flex_cnt_pkg.sv
// rtl/flex_cnt_pkg.sv - shared types and default widths for the flex counter family
//
// Purpose: state encoding and default parameter values shared by
//          flex_counter_ctl and future TX timers.
// Contents:
//   fc_state_t          RUN / HALT counter state
//   DEF_NUM_CNT_BITS    default count width
//   DEF_NUM_WRAP_BITS   default wrap counter width
//   DEF_LOOKAHEAD       default early_flag distance
//   DEF_RST_VAL         default count value after reset
package flex_cnt_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fc_state_t;

  localparam int DEF_NUM_CNT_BITS  = 4;
  localparam int DEF_NUM_WRAP_BITS = 3;
  localparam int DEF_LOOKAHEAD     = 1;
  localparam int DEF_RST_VAL       = 1;

endpackage

// File: rtl/flex_counter_ctl_if.sv
// rtl/flex_counter_ctl_if.sv - control/status bundle between TX controller and flex counter
//
// Purpose: groups the counter's control inputs and status outputs.
// Modports:
//   master  TX controller side: drives clear, count_enable, one_shot,
//           start_value, rollover_value; observes count_out, rollover_flag,
//           early_flag, done, wrap_count
//   slave   counter side: the reverse directions
interface flex_counter_ctl_if
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
  parameter int NUM_WRAP_BITS = DEF_NUM_WRAP_BITS
);

  logic                     clear;
  logic                     count_enable;
  logic                     one_shot;
  logic [NUM_CNT_BITS-1:0]  start_value;
  logic [NUM_CNT_BITS-1:0]  rollover_value;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     early_flag;
  logic                     done;
  logic [NUM_WRAP_BITS-1:0] wrap_count;

  modport master (
    output clear, count_enable, one_shot, start_value, rollover_value,
    input  count_out, rollover_flag, early_flag, done, wrap_count
  );

  modport slave (
    input  clear, count_enable, one_shot, start_value, rollover_value,
    output count_out, rollover_flag, early_flag, done, wrap_count
  );

endinterface

// File: rtl/flex_counter_ctl.sv
// rtl/flex_counter_ctl.sv - programmable flex counter with lookahead flag, one-shot and wrap count
//
// Purpose: USB TX path timing counter (bit-stuff, byte, packet length).
//          Counts from start_value to rollover_value, then reloads
//          (auto-reload) or halts (one-shot). Counts rollovers since the
//          last clear in a saturating wrap counter.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    flex_counter_ctl_if.slave:
//            in : clear, count_enable, one_shot, start_value, rollover_value
//            out: count_out, rollover_flag, early_flag, done, wrap_count
//          All outputs are registered.
module flex_counter_ctl
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
  parameter int LOOKAHEAD     = DEF_LOOKAHEAD,
  parameter int NUM_WRAP_BITS = DEF_NUM_WRAP_BITS,
  parameter int RST_VAL       = DEF_RST_VAL
) (
  input logic               clk,
  input logic               n_rst,
  flex_counter_ctl_if.slave bus
);

  localparam logic [NUM_CNT_BITS-1:0] LA_W  = NUM_CNT_BITS'(LOOKAHEAD);
  localparam logic [NUM_CNT_BITS-1:0] RST_W = NUM_CNT_BITS'(RST_VAL);

  fc_state_t                state_q, state_d;
  logic [NUM_CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [NUM_WRAP_BITS-1:0] wrap_q, wrap_d;
  logic                     done_q, done_d;
  logic                     roll_q, roll_d;
  logic                     early_q, early_d;
  logic [NUM_CNT_BITS-1:0]  early_target;

  // Lookahead point wraps modulo 2^NUM_CNT_BITS, like the count itself.
  assign early_target = bus.rollover_value - LA_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    done_d  = done_q;

    if (bus.clear) begin
      state_d = RUN;
      cnt_d   = bus.start_value;
      wrap_d  = '0;
      done_d  = 1'b0;
    end else if (state_q == RUN && bus.count_enable) begin
      if (cnt_q == bus.rollover_value) begin
        if (wrap_q != '1) begin
          wrap_d = wrap_q + 1'b1;
        end
        if (bus.one_shot) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else begin
          cnt_d = bus.start_value;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Flags are evaluated on the next-state count so that, once registered,
    // they line up with the count value they describe.
    roll_d  = (state_d == RUN) && (cnt_d == bus.rollover_value);
    early_d = (state_d == RUN) && (cnt_d == early_target);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RUN;
      cnt_q   <= RST_W;
      wrap_q  <= '0;
      done_q  <= 1'b0;
      roll_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      roll_q  <= roll_d;
      early_q <= early_d;
    end
  end

  assign bus.count_out     = cnt_q;
  assign bus.wrap_count    = wrap_q;
  assign bus.done          = done_q;
  assign bus.rollover_flag = roll_q;
  assign bus.early_flag    = early_q;

endmodule

// File: tb/tb_flex_counter_ctl.sv
// tb/tb_flex_counter_ctl.sv - self-checking bench for flex_counter_ctl
module tb_flex_counter_ctl;

  logic clk;
  logic n_rst;

  flex_counter_ctl_if #(.NUM_CNT_BITS(4), .NUM_WRAP_BITS(3)) bus ();

  flex_counter_ctl #(
    .NUM_CNT_BITS (4),
    .LOOKAHEAD    (1),
    .NUM_WRAP_BITS(3),
    .RST_VAL      (1)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic       os;
    logic [3:0] sv;
    logic [3:0] rv;
    logic [3:0] e_cnt;
    logic       e_roll;
    logic       e_early;
    logic       e_done;
    logic [2:0] e_wrap;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic c, input logic e, input logic o,
                     input logic [3:0] s, input logic [3:0] r,
                     input logic [3:0] ec, input logic er, input logic ee,
                     input logic ed, input logic [2:0] ew);
    vec_t v;
    v.clr = c; v.en = e; v.os = o; v.sv = s; v.rv = r;
    v.e_cnt = ec; v.e_roll = er; v.e_early = ee; v.e_done = ed; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic c, input logic e, input logic o,
                       input logic [3:0] s, input logic [3:0] r);
    bus.clear          = c;
    bus.count_enable   = e;
    bus.one_shot       = o;
    bus.start_value    = s;
    bus.rollover_value = r;
  endtask

  task automatic check(input string name, input logic [3:0] ec, input logic er,
                       input logic ee, input logic ed, input logic [2:0] ew);
    logic [9:0] act, exp;
    act = {bus.count_out, bus.rollover_flag, bus.early_flag, bus.done, bus.wrap_count};
    exp = {ec, er, ee, ed, ew};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d roll=%0b early=%0b done=%0b wrap=%0d, want cnt=%0d roll=%0b early=%0b done=%0b wrap=%0d",
               name, bus.count_out, bus.rollover_flag, bus.early_flag, bus.done, bus.wrap_count,
               ec, er, ee, ed, ew);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    drive(0, 0, 0, 4'd1, 4'd4);

    // auto-reload start=1 roll=4
    add(1,0,0,1,4,  1,0,0,0,0);
    add(0,1,0,1,4,  2,0,0,0,0);
    add(0,1,0,1,4,  3,0,1,0,0);
    add(0,1,0,1,4,  4,1,0,0,0);
    add(0,1,0,1,4,  1,0,0,0,1);
    add(0,1,0,1,4,  2,0,0,0,1);
    add(0,0,0,1,4,  2,0,0,0,1);
    add(0,1,0,1,4,  3,0,1,0,1);
    add(0,1,0,1,4,  4,1,0,0,1);
    add(0,1,0,1,4,  1,0,0,0,2);
    // one-shot start=2 roll=5
    add(1,0,1,2,5,  2,0,0,0,0);
    add(0,1,1,2,5,  3,0,0,0,0);
    add(0,1,1,2,5,  4,0,1,0,0);
    add(0,1,1,2,5,  5,1,0,0,0);
    add(0,1,1,2,5,  5,0,0,1,1);
    add(0,1,1,2,5,  5,0,0,1,1);
    add(0,1,0,2,5,  5,0,0,1,1);
    add(1,1,1,2,5,  2,0,0,0,0);
    // wrap-around start=14 roll=1
    add(1,0,0,14,1, 14,0,0,0,0);
    add(0,1,0,14,1, 15,0,0,0,0);
    add(0,1,0,14,1,  0,0,1,0,0);
    add(0,1,0,14,1,  1,1,0,0,0);
    add(0,1,0,14,1, 14,0,0,0,1);
    add(0,1,0,14,1, 15,0,0,0,1);
    add(0,1,0,14,1,  0,0,1,0,1);
    add(0,1,0,14,1,  1,1,0,0,1);
    // clear and enable together at count==roll: clear wins
    add(1,1,0,14,1, 14,0,0,0,0);
    // rollover_value changed mid-count
    add(0,0,0,14,15, 14,0,1,0,0);
    add(0,1,0,14,15, 15,1,0,0,0);
    add(0,1,0,14,15, 14,0,1,0,1);
    // saturation start=roll=3
    add(1,0,0,3,3,  3,1,0,0,0);
    for (int i = 1; i <= 10; i++) begin
      add(0,1,0,3,3, 3,1,0,0, (i > 7) ? 3'd7 : 3'(i));
    end

    @(posedge clk);
    #1;
    check("reset_values", 4'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].os, vecs[i].sv, vecs[i].rv);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_roll,
            vecs[i].e_early, vecs[i].e_done, vecs[i].e_wrap);
    end

    // async reset mid-count (count=3, wrap=7), away from any clock edge
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset", 4'd1, 1'b0, 1'b0, 1'b0, 3'd0);

    // flags computed from registered state after reset: RST_VAL==rollover_value
    drive(0, 0, 0, 4'd1, 4'd1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_roll_flag", 4'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(0, 1, 0, 4'd1, 4'd1);
    @(posedge clk);
    #1;
    check("start_eq_roll_wrap", 4'd1, 1'b1, 1'b0, 1'b0, 3'd1);
    drive(0, 0, 0, 4'd1, 4'd2);
    @(posedge clk);
    #1;
    check("post_reset_early_flag", 4'd1, 1'b0, 1'b1, 1'b0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
